// File: rtl/opc5ls_memctl.sv
// OPC5LS CPU-to-memory controller: latches a CPU access, handshakes with memory, stalls via clken.
// Optional REQ-phase timeout with sticky bus_err is enabled by defining MEMCTL_TIMEOUT_EN.
module opc5ls_memctl #(
    parameter int unsigned WAIT_STATES = 1,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] address,
    input  logic [15:0] dout,
    input  logic        rnw,
    input  logic        vda,
    input  logic        vpa,
    output logic [15:0] din,
    output logic        clken,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_req,
    output logic        mem_we,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack,
    output logic        bus_err
);

    if (WAIT_STATES > 15) begin : g_bad_wait_states
        $error("WAIT_STATES must be in 0..15");
    end
    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("TIMEOUT must be in 1..255");
    end

    typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

    localparam logic [3:0] WaitLoad = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    state_e      state_q, state_d;
    logic [15:0] din_q, din_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        rnw_q, rnw_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [3:0]  wait_q, wait_d;
    logic        mreq;

`ifdef MEMCTL_TIMEOUT_EN
    localparam logic [7:0] TmoLast = 8'(TIMEOUT - 1);
    logic [7:0] tmo_q, tmo_d;
    logic       bus_err_q, bus_err_d;
`endif

    assign mreq = vda | vpa;

    always_comb begin
        state_d   = state_q;
        din_d     = din_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rnw_d     = rnw_q;
        mem_req_d = mem_req_q;
        mem_we_d  = mem_we_q;
        wait_d    = wait_q;
`ifdef MEMCTL_TIMEOUT_EN
        tmo_d     = tmo_q;
        bus_err_d = bus_err_q;
`endif
        case (state_q)
            StIdle: begin
                if (mreq) begin
                    addr_d    = address;
                    wdata_d   = dout;
                    rnw_d     = rnw;
                    mem_req_d = 1'b1;
                    mem_we_d  = ~rnw;
                    state_d   = StReq;
`ifdef MEMCTL_TIMEOUT_EN
                    tmo_d     = 8'd0;
`endif
                end
            end
            StReq: begin
                // An ack in the expiry cycle still completes normally.
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    if (rnw_q) begin
                        din_d = mem_rdata;
                    end
                    if (WAIT_STATES > 0) begin
                        state_d = StWait;
                        wait_d  = WaitLoad;
                    end else begin
                        state_d = StDone;
                    end
                end
`ifdef MEMCTL_TIMEOUT_EN
                else if (tmo_q == TmoLast) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    if (rnw_q) begin
                        din_d = 16'hFFFF;
                    end
                    bus_err_d = 1'b1;
                    state_d   = StDone;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
`endif
            end
            StWait: begin
                if (wait_q == 4'd0) begin
                    state_d = StDone;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            din_q     <= 16'h0000;
            addr_q    <= 16'h0000;
            wdata_q   <= 16'h0000;
            rnw_q     <= 1'b0;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            wait_q    <= 4'd0;
`ifdef MEMCTL_TIMEOUT_EN
            tmo_q     <= 8'd0;
            bus_err_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            din_q     <= din_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rnw_q     <= rnw_d;
            mem_req_q <= mem_req_d;
            mem_we_q  <= mem_we_d;
            wait_q    <= wait_d;
`ifdef MEMCTL_TIMEOUT_EN
            tmo_q     <= tmo_d;
            bus_err_q <= bus_err_d;
`endif
        end
    end

    always_comb begin
        clken = 1'b1;
        if (!reset) begin
            case (state_q)
                StIdle:  clken = ~mreq;
                StReq:   clken = 1'b0;
                StWait:  clken = 1'b0;
                StDone:  clken = 1'b1;
                default: clken = 1'b1;
            endcase
        end
    end

    assign din       = din_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
`ifdef MEMCTL_TIMEOUT_EN
    assign bus_err   = bus_err_q;
`else
    assign bus_err   = 1'b0;
`endif

endmodule
